// File: rtl/char_sweep_ctrl.sv
`default_nettype none
// =============================================================================
// char_sweep_ctrl : slope x load grid sweep sequencer with measurement capture
// Rev 1.0
// =============================================================================
module char_sweep_ctrl #(
  parameter int NB_SLOPES     = 7,
  parameter int NB_CAPA       = 7,
  parameter int SETTLE_CYCLES = 10,
  parameter int MEAS_W        = 16,
  localparam int C_SLOPE_W    = (NB_SLOPES > 1) ? $clog2(NB_SLOPES) : 1,
  localparam int C_CAPA_W     = (NB_CAPA > 1) ? $clog2(NB_CAPA) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [1:0]           mode,
  output logic [C_SLOPE_W-1:0] slope_idx,
  output logic [C_CAPA_W-1:0]  capa_idx,
  output logic                 din,
  input  logic                 dout,
  input  logic                 meas_valid,
  input  logic [MEAS_W-1:0]    meas_value,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [C_SLOPE_W-1:0] res_slope,
  output logic [C_CAPA_W-1:0]  res_capa,
  output logic                 res_edge,
  output logic [MEAS_W-1:0]    res_value,
  output logic                 res_last,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [1:0]           err_code
);

  localparam int C_CNT_W = $clog2(SETTLE_CYCLES);
  localparam logic [C_CNT_W-1:0]   C_CNT_LAST   = C_CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [C_SLOPE_W-1:0] C_SLOPE_LAST = C_SLOPE_W'(NB_SLOPES - 1);
  localparam logic [C_CAPA_W-1:0]  C_CAPA_LAST  = C_CAPA_W'(NB_CAPA - 1);

  localparam logic [1:0] C_MODE_RISE = 2'd1;
  localparam logic [1:0] C_MODE_BOTH = 2'd2;
  localparam logic [1:0] C_MODE_ILL  = 2'd3;

  localparam logic [1:0] C_ERR_NONE     = 2'd0;
  localparam logic [1:0] C_ERR_TIMEOUT  = 2'd1;
  localparam logic [1:0] C_ERR_MISMATCH = 2'd2;
  localparam logic [1:0] C_ERR_MODE     = 2'd3;

  typedef enum logic [3:0] {
    S_IDLE, S_PRESET, S_EDGE1, S_EMIT1, S_EDGE2, S_EMIT2, S_NEXT, S_DONE, S_ERROR
  } state_t;

  state_t                 state_q, state_d;
  logic [C_CNT_W-1:0]     cnt_q, cnt_d;
  logic [1:0]             mode_q, mode_d;
  logic [C_SLOPE_W-1:0]   slope_q, slope_d;
  logic [C_CAPA_W-1:0]    capa_q, capa_d;
  logic                   din_q, din_d;
  logic                   got_q, got_d;
  logic [MEAS_W-1:0]      meas_q, meas_d;
  logic                   res_valid_q, res_valid_d;
  logic [C_SLOPE_W-1:0]   res_slope_q, res_slope_d;
  logic [C_CAPA_W-1:0]    res_capa_q, res_capa_d;
  logic                   res_edge_q, res_edge_d;
  logic [MEAS_W-1:0]      res_value_q, res_value_d;
  logic                   res_last_q, res_last_d;
  logic                   err_q, err_d;
  logic [1:0]             err_code_q, err_code_d;

  logic                   rest_lvl, both, last_point, win_end, hit, measured;
  logic [MEAS_W-1:0]      meas_cur;

  always_comb begin
    rest_lvl   = (mode_q == C_MODE_RISE);
    both       = (mode_q == C_MODE_BOTH);
    last_point = (slope_q == C_SLOPE_LAST) && (capa_q == C_CAPA_LAST);
    win_end    = (cnt_q == C_CNT_LAST);
    // a strobe on the closing window cycle still counts as the measurement
    hit        = got_q | meas_valid;
    meas_cur   = got_q ? meas_q : meas_value;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    slope_d     = slope_q;
    capa_d      = capa_q;
    din_d       = din_q;
    got_d       = got_q;
    meas_d      = meas_q;
    res_valid_d = res_valid_q;
    res_slope_d = res_slope_q;
    res_capa_d  = res_capa_q;
    res_edge_d  = res_edge_q;
    res_value_d = res_value_q;
    res_last_d  = res_last_q;
    err_d       = err_q;
    err_code_d  = err_code_q;
    measured    = (state_q == S_EDGE1) || both;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          err_d = 1'b1;
          err_code_d = C_ERR_MODE;
          if (mode != C_MODE_ILL) begin
            err_d      = 1'b0;
            err_code_d = C_ERR_NONE;
            mode_d     = mode;
            slope_d    = '0;
            capa_d     = '0;
            cnt_d      = '0;
            din_d      = (mode == C_MODE_RISE);
            state_d    = S_PRESET;
          end
        end
      end
      S_PRESET: begin
        if (win_end) begin
          cnt_d   = '0;
          din_d   = ~din_q;
          got_d   = 1'b0;
          state_d = S_EDGE1;
        end else begin
          cnt_d = cnt_q + C_CNT_W'(1);
        end
      end
      S_EDGE1, S_EDGE2: begin
        if (meas_valid && !got_q) begin
          got_d  = 1'b1;
          meas_d = meas_value;
        end
        if (!win_end) begin
          cnt_d = cnt_q + C_CNT_W'(1);
        end else begin
          cnt_d = '0;
          if (dout == din_q) begin
            err_d = 1'b1;
            err_code_d = C_ERR_MISMATCH;
            din_d = rest_lvl;
            state_d = S_ERROR;
          end else if (measured && !hit) begin
            err_d = 1'b1;
            err_code_d = C_ERR_TIMEOUT;
            din_d = rest_lvl;
            state_d = S_ERROR;
          end else if (measured) begin
            res_valid_d = 1'b1;
            res_slope_d = slope_q;
            res_capa_d  = capa_q;
            res_edge_d  = ~din_q;
            res_value_d = meas_cur;
            res_last_d  = last_point && ((state_q == S_EDGE2) || !both);
            state_d     = (state_q == S_EDGE1) ? S_EMIT1 : S_EMIT2;
          end else begin
            state_d = S_NEXT;
          end
        end
      end
      S_EMIT1, S_EMIT2: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          if (state_q == S_EMIT1) begin
            din_d   = ~din_q;
            got_d   = 1'b0;
            cnt_d   = '0;
            state_d = S_EDGE2;
          end else begin
            state_d = S_NEXT;
          end
        end
      end
      S_NEXT: begin
        if (last_point) begin
          state_d = S_DONE;
        end else begin
          if (capa_q == C_CAPA_LAST) begin
            capa_d  = '0;
            slope_d = slope_q + C_SLOPE_W'(1);
          end else begin
            capa_d = capa_q + C_CAPA_W'(1);
          end
          cnt_d   = '0;
          state_d = S_PRESET;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERROR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mode_q      <= '0;
      slope_q     <= '0;
      capa_q      <= '0;
      din_q       <= 1'b0;
      got_q       <= 1'b0;
      meas_q      <= '0;
      res_valid_q <= 1'b0;
      res_slope_q <= '0;
      res_capa_q  <= '0;
      res_edge_q  <= 1'b0;
      res_value_q <= '0;
      res_last_q  <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= C_ERR_NONE;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      slope_q     <= slope_d;
      capa_q      <= capa_d;
      din_q       <= din_d;
      got_q       <= got_d;
      meas_q      <= meas_d;
      res_valid_q <= res_valid_d;
      res_slope_q <= res_slope_d;
      res_capa_q  <= res_capa_d;
      res_edge_q  <= res_edge_d;
      res_value_q <= res_value_d;
      res_last_q  <= res_last_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
    end
  end

  assign slope_idx = slope_q;
  assign capa_idx  = capa_q;
  assign din       = din_q;
  assign res_valid = res_valid_q;
  assign res_slope = res_slope_q;
  assign res_capa  = res_capa_q;
  assign res_edge  = res_edge_q;
  assign res_value = res_value_q;
  assign res_last  = res_last_q;
  assign busy      = (state_q != S_IDLE) && (state_q != S_ERROR);
  assign done      = (state_q == S_DONE);
  assign err       = err_q;
  assign err_code  = err_code_q;

endmodule
`default_nettype wire

// File: tb/tb_char_sweep_ctrl.sv
`default_nettype none
// =============================================================================
// tb_char_sweep_ctrl : randomized board model + grid-order reference checker
// Rev 1.0
// =============================================================================
module tb_char_sweep_ctrl;
  localparam int NS = 2, NC = 3, ST = 4, MW = 16;
  localparam int NPTS = NS * NC;

  logic clk, rst_n, start, din, dout, meas_valid, res_valid, res_ready;
  logic res_edge, res_last, busy, done, err;
  logic [1:0] mode, capa_idx, res_capa, err_code;
  logic [0:0] slope_idx, res_slope;
  logic [MW-1:0] meas_value, res_value;

  int n_cmp = 0, n_bad = 0;
  logic [MW-1:0] vals [64];
  int sweep_id = 0, suppress_edge = -1, rec_idx = 0, n_exp = 0, n_full = 0;
  int cur_mode = 0, ready_mode = 0;
  bit stuck = 0, mon_en = 0;

  char_sweep_ctrl #(.NB_SLOPES(NS), .NB_CAPA(NC), .SETTLE_CYCLES(ST), .MEAS_W(MW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .slope_idx(slope_idx), .capa_idx(capa_idx), .din(din), .dout(dout),
    .meas_valid(meas_valid), .meas_value(meas_value),
    .res_valid(res_valid), .res_ready(res_ready), .res_slope(res_slope),
    .res_capa(res_capa), .res_edge(res_edge), .res_value(res_value),
    .res_last(res_last), .busy(busy), .done(done), .err(err), .err_code(err_code)
  );

  // ideal inverter unless forced stuck high
  assign dout = stuck ? 1'b1 : ~din;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // board model: one first strobe per edge at a random window slot, plus decoys
  initial begin : board
    int seen = 0, ecnt = 0, cur = -1, pos = 0, fire = 0, decoy = 0;
    logic din_prev = 1'b0;
    logic busy_prev = 1'b0;
    meas_valid = 1'b0;
    meas_value = '0;
    forever begin
      @(posedge clk); #2;
      if (seen != sweep_id) begin seen = sweep_id; ecnt = 0; cur = -1; end
      meas_valid = 1'b0;
      if (din !== din_prev && busy_prev === 1'b1) begin
        cur = ecnt; ecnt++; pos = 0;
        fire = $urandom_range(0, ST - 1);
        decoy = $urandom_range(0, ST - 1);
      end else begin
        pos++;
      end
      if (cur >= 0 && cur < 64) begin
        if (cur != suppress_edge) begin
          if (pos == fire) begin meas_valid = 1'b1; meas_value = vals[cur]; end
          else if (pos > fire && pos == decoy) begin meas_valid = 1'b1; meas_value = ~vals[cur]; end
        end else if (pos == ST) begin
          meas_valid = 1'b1; meas_value = ~vals[cur];
        end
      end
      din_prev = din;
      busy_prev = busy;
    end
  end

  initial begin : ready_drv
    int seen = 0, stall_left = 0;
    bit stalled = 0;
    res_ready = 1'b1;
    forever begin
      @(posedge clk); #3;
      if (seen != sweep_id) begin seen = sweep_id; stalled = 0; stall_left = 0; end
      case (ready_mode)
        0: res_ready = 1'b1;
        1: res_ready = ($urandom_range(0, 2) != 0);
        2: begin
          if (!stalled && res_valid === 1'b1 && rec_idx == 2) begin stalled = 1; stall_left = 5; end
          if (stall_left > 0) begin res_ready = 1'b0; stall_left--; end
          else res_ready = 1'b1;
        end
        default: res_ready = 1'b0;
      endcase
    end
  end

  // expected record j: grid point in slope-major order, value from edge it measured
  initial begin : monitor
    int seen = 0, p, ei;
    bit bm;
    forever begin
      @(negedge clk);
      if (seen != sweep_id) begin seen = sweep_id; rec_idx = 0; end
      if (mon_en && res_valid === 1'b1) begin
        bm = (cur_mode == 2);
        if (rec_idx >= n_exp) begin
          n_cmp++; n_bad++;
          $error("FAIL extra_record: observed index %0d expected count %0d", rec_idx, n_exp);
        end else begin
          p  = bm ? rec_idx / 2 : rec_idx;
          ei = bm ? rec_idx : 2 * rec_idx;
          chk("res_slope", res_slope, p / NC);
          chk("res_capa", res_capa, p % NC);
          chk("res_edge", res_edge, bm ? rec_idx % 2 : (cur_mode == 1));
          chk("res_value", res_value, vals[ei]);
          chk("res_last", res_last, rec_idx == n_full - 1);
          if (res_ready === 1'b1) rec_idx++;
        end
      end
    end
  end

  task automatic setup(input int m, input int rmode, input int supp, input bit stk, input int exp_recs);
    sweep_id++;
    foreach (vals[i]) vals[i] = MW'($urandom);
    cur_mode = m;
    n_full = ((m == 2) ? 2 : 1) * NPTS;
    n_exp = exp_recs;
    suppress_edge = supp;
    stuck = stk;
    ready_mode = rmode;
    mon_en = 1;
    mode = 2'(m);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_sweep(input string nm, input int m, input int rmode, input int supp,
                           input bit stk, input int exp_code, input int exp_recs,
                           input int exp_done_k, input bit poke);
    int k = 0, done_cnt = 0, done_k = -1;
    bit fin = 0;
    setup(m, rmode, supp, stk, exp_recs);
    chk({nm, "_busy_after_start"}, busy, 1);
    chk({nm, "_din_rest"}, din, m == 1);
    chk({nm, "_err_cleared"}, err, 0);
    while (!fin) begin
      @(posedge clk); #1; k++;
      if (done === 1'b1) begin done_cnt++; done_k = k; fin = 1; end
      else if (err === 1'b1) fin = 1;
      else if (k >= 3000) begin
        n_cmp++; n_bad++;
        $error("FAIL %s_sweep_timeout: observed %0d cycles without end expected < 3000", nm, k);
        fin = 1;
      end
    end
    if (done_cnt > 0) begin
      if (poke) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk({nm, "_done_one_cycle"}, done, 0);
      chk({nm, "_idle_after_done"}, busy, 0);
    end else begin
      chk({nm, "_err_busy_low"}, busy, 0);
      chk({nm, "_err_din_rest"}, din, m == 1);
      chk({nm, "_err_no_valid"}, res_valid, 0);
      repeat (3) begin
        @(posedge clk); #1;
        if (done === 1'b1) done_cnt++;
      end
    end
    chk({nm, "_record_count"}, rec_idx, exp_recs);
    chk({nm, "_err"}, err, exp_code != 0);
    chk({nm, "_err_code"}, err_code, exp_code);
    chk({nm, "_done_pulses"}, done_cnt, exp_code == 0);
    if (exp_done_k >= 0) chk({nm, "_cycles_to_done"}, done_k, exp_done_k);
  endtask

  initial begin : main
    int w;
    rst_n = 1'b0; start = 1'b0; mode = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_din", din, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", {err, err_code}, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_idx", {slope_idx, capa_idx}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // per point 3*ST+2 (single) / 3*ST+3 (both) cycles
    run_sweep("fall", 0, 0, -1, 0, 0, NPTS, NPTS * (3 * ST + 2), 1);
    run_sweep("both", 2, 0, -1, 0, 0, 2 * NPTS, NPTS * (3 * ST + 3), 0);
    run_sweep("rise", 1, 1, -1, 0, 0, NPTS, -1, 0);
    run_sweep("backpressure", 0, 2, -1, 0, 0, NPTS, NPTS * (3 * ST + 2) + 5, 0);
    // point (1,0) = point 3; its first edge is board edge 6 in single mode
    run_sweep("timeout_e1", 0, 0, 6, 0, 1, 3, -1, 0);
    run_sweep("timeout_e2", 2, 0, 7, 0, 1, 7, -1, 0);
    run_sweep("timeout_rise", 1, 1, 4, 0, 1, 2, -1, 0);
    // missing strobe and stuck output on the same edge: mismatch wins
    run_sweep("mismatch", 0, 0, 0, 1, 2, 0, -1, 0);

    stuck = 1'b0;
    mode = 2'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("mode3_busy_low", busy, 0);
      @(posedge clk); #1;
    end
    chk("mode3_err", err, 1);
    chk("mode3_err_code", err_code, 3);
    run_sweep("after_mode3", 2, 1, -1, 0, 0, 2 * NPTS, -1, 0);

    setup(1, 3, -1, 0, NPTS);
    w = 0;
    while (res_valid !== 1'b1 && w < 200) begin @(posedge clk); #1; w++; end
    chk("rst_mid_emit_reached", res_valid, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    mon_en = 0;
    chk("rstm_din", din, 0);
    chk("rstm_idx", {slope_idx, capa_idx}, 0);
    chk("rstm_res_valid", res_valid, 0);
    chk("rstm_res_fields", {res_slope, res_capa, res_edge, res_last}, 0);
    chk("rstm_res_value", res_value, 0);
    chk("rstm_busy_done", {busy, done}, 0);
    chk("rstm_err", {err, err_code}, 0);
    ready_mode = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: observed simulation still running expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
